// File: rtl/asrv32_mem_responder.sv
// -----------------------------------------------------------------------------
// asrv32_mem_responder
//
// Memory-side responder for the core's request/acknowledge memory interface.
// It serves instruction fetches and load/store requests from a single-port,
// word-organised RAM with a per-byte write mask and a fixed number of wait
// states. Only one request is outstanding at a time.
//
// Handshake: the requester raises i_req with i_we/i_addr/i_wdata/i_wr_mask
// stable. The request is taken at the first rising edge where the responder
// is IDLE (o_busy=0). Acceptance is the "ready" side of the handshake. After
// that edge all inputs are ignored until o_ack pulses for exactly one cycle.
// o_rdata (reads) and o_err are valid only while o_ack=1. If i_req is still
// high after the ack, it is taken again on the next IDLE edge.
//
// Parameters
//   ADDR_WIDTH   word-address bits; depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  extra cycles between accept and ack (0..15)
//
// Optional feature (compile-time macro ASRV32_MEM_RANGE_CHECK_EN)
//   defined   : byte addresses with any bit set in [31:ADDR_WIDTH+2] are out
//               of range. Such a request still gets an ack, with o_err=1. A
//               write is dropped, and a read returns 0.
//   undefined : upper address bits are ignored (accesses wrap), o_err=0.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_req        request strobe, sampled only in IDLE
//   i_we         1 = write, 0 = read
//   i_addr       byte address, [1:0] ignored
//   i_wdata      write data
//   i_wr_mask    byte enables, bit k -> i_wdata[8k+7:8k]
//   o_rdata      read data, registered, held between read acks
//   o_ack        one-cycle completion pulse
//   o_busy       1 while a request is in flight (WAIT or RESP)
//   o_err        out-of-range flag, valid with o_ack
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module asrv32_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wr_mask,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Value loaded into the wait counter when WAIT is entered. WAIT is left
  // once the counter reads zero, so WAIT lasts WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;

  // Request latched at accept.
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              mask_q;
  logic                    oor_q;

  logic [31:0]             rdata_q;
  logic                    ack_q;
  logic                    busy_q;
  logic                    err_q;

  logic                    accept;
  logic                    enter_resp;
  logic                    in_oor;

  // The request committed on the edge entering RESP. With WAIT_CYCLES=0
  // that edge is also the accept edge, so the live inputs are used. The
  // latched copy is not loaded until the same edge.
  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [31:0]             cur_wdata;
  logic [3:0]              cur_mask;
  logic                    cur_oor;

  logic [31:0]             mem [0:DEPTH-1];

`ifdef ASRV32_MEM_RANGE_CHECK_EN
  assign in_oor = |i_addr[31:ADDR_WIDTH+2];
`else
  assign in_oor = 1'b0;
`endif

  // Byte-offset bits are never used. The upper bits are used only when the
  // range check is enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_mask  = mask_q;
    cur_oor   = oor_q;
    if (state_q == ST_IDLE) begin
      cur_we    = i_we;
      cur_addr  = i_addr[ADDR_WIDTH+1:2];
      cur_wdata = i_wdata;
      cur_mask  = i_wr_mask;
      cur_oor   = in_oor;
    end
  end

  // ---------------------------------------------------------------------------
  // State, request latch and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      oor_q   <= 1'b0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= i_we;
        addr_q  <= i_addr[ADDR_WIDTH+1:2];
        wdata_q <= i_wdata;
        mask_q  <= i_wr_mask;
        oor_q   <= in_oor;
      end
      // The ack, busy and err outputs are registered alongside the state.
      // The ack is therefore high exactly while the FSM is in RESP.
      ack_q  <= enter_resp;
      busy_q <= (state_d != ST_IDLE);
      err_q  <= enter_resp & cur_oor;
      if (enter_resp && !cur_we) begin
        rdata_q <= cur_oor ? 32'd0 : mem[cur_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port (contents are not reset)
  // ---------------------------------------------------------------------------
  // A write commits on the edge that enters RESP. If reset is asserted at
  // that edge, the request is being dropped, so the write must not land.
  always_ff @(posedge i_clk) begin
    if (!i_rst && enter_resp && cur_we && !cur_oor) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_mask[k]) begin
          mem[cur_addr][8*k +: 8] <= cur_wdata[8*k +: 8];
        end
      end
    end
  end

  assign o_rdata     = rdata_q;
  assign o_ack       = ack_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_asrv32_mem_responder.sv
module tb_asrv32_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dut: WAIT_CYCLES=1
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] rdata;
  logic        ack, busy, err;
  logic [1:0]  dbg;

  // dut0: WAIT_CYCLES=0
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [3:0]  mask0 = 4'd0;
  logic [31:0] rdata0;
  logic        ack0, busy0, err0;
  logic [1:0]  dbg0;

  asrv32_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_wr_mask(mask), .o_rdata(rdata), .o_ack(ack),
    .o_busy(busy), .o_err(err), .o_dbg_state(dbg)
  );

  asrv32_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we0), .i_addr(addr0),
    .i_wdata(wdata0), .i_wr_mask(mask0), .o_rdata(rdata0), .o_ack(ack0),
    .o_busy(busy0), .o_err(err0), .o_dbg_state(dbg0)
  );

  // ---------------------------------------------------------------------------
  // Driver: one request on dut. lat = number of edges after the accept edge
  // up to the edge at which ack is sampled high (-1 on timeout). Returns at
  // the negedge where ack is high.
  // ---------------------------------------------------------------------------
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; mask = m;
    @(posedge clk);
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (ack) begin
        lat = i; rd = rdata; er = err;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tests++; if (ack !== 1'b0)       begin fails++; $display("FAIL reset_ack got %b exp 0", ack); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (rdata !== 32'd0)    begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    tests++; if (dbg !== 2'd0)       begin fails++; $display("FAIL reset_state got %0d exp 0", dbg); end
    tests++; if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 32'd0)
      begin fails++; $display("FAIL reset_dut0 got ack=%b busy=%b rdata=%h exp 0", ack0, busy0, rdata0); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    tests++; if (lat !== 2)          begin fails++; $display("FAIL wr_latency got %0d exp 2", lat); end
    tests++; if (er !== 1'b0)        begin fails++; $display("FAIL wr_err got %b exp 0", er); end
    tests++; if (rd !== 32'd0)       begin fails++; $display("FAIL wr_rdata_hold got %h exp 0", rd); end
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL wr_busy_in_ack got %b exp 1", busy); end
    @(negedge clk);
    tests++; if (ack !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL ack_one_cycle got ack=%b busy=%b exp 0 0", ack, busy); end
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    tests++; if (lat !== 2)          begin fails++; $display("FAIL rd_latency got %0d exp 2", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    @(negedge clk);
    tests++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data_held got %h exp deadbeef", rdata); end
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL mask_wr_rdata_hold got %h exp deadbeef", rd); end
    access(1'b1, 32'h22, 32'hFFFFFFFF, 4'b0000, lat, rd, er); // same word, zero mask
    tests++; if (lat !== 2)          begin fails++; $display("FAIL mask0_ack got %0d exp 2", lat); end
    access(1'b0, 32'h23, 32'h0, 4'h0, lat, rd, er);           // byte offset ignored
    tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL mask_data got %h exp 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BADF00D; mask0 = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      tests++;
      if (ack0 !== 1'(i % 2) || busy0 !== 1'(i % 2)) begin
        fails++; $display("FAIL b2b_cycle%0d got ack=%b busy=%b exp %0d", i, ack0, busy0, i % 2);
      end
    end
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    tests++; if (ack0 !== 1'b1 || rdata0 !== 32'h0BADF00D)
      begin fails++; $display("FAIL w0_read got ack=%b rdata=%h exp 1 0badf00d", ack0, rdata0); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, lat, rd, er);
    access(1'b1, 32'h4000, 32'h55667788, 4'hF, lat, rd, er);
`ifdef ASRV32_MEM_RANGE_CHECK_EN
    tests++; if (lat !== 2 || er !== 1'b1) begin fails++; $display("FAIL oor_wr got lat=%0d err=%b exp 2 1", lat, er); end
    access(1'b0, 32'h4000, 32'h0, 4'h0, lat, rd, er);
    tests++; if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL oor_rd got err=%b rd=%h exp 1 0", er, rd); end
    @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL oor_err_after got %b exp 0", err); end
    access(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    tests++; if (er !== 1'b0 || rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL oor_word0 got err=%b rd=%h exp 0 a5a5a5a5", er, rd); end
`else
    tests++; if (lat !== 2 || er !== 1'b0) begin fails++; $display("FAIL wrap_wr got lat=%0d err=%b exp 2 0", lat, er); end
    access(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    tests++; if (er !== 1'b0 || rd !== 32'h55667788) begin fails++; $display("FAIL wrap_word0 got err=%b rd=%h exp 0 55667788", er, rd); end
`endif
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] rd; logic er;
    access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_rst_rd got %h exp deadbeef", rd); end
    #2 rst = 1'b1;
    #1;
    tests++; if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rdata !== 32'd0)
      begin fails++; $display("FAIL async_rst got ack=%b busy=%b err=%b rdata=%h exp 0", ack, busy, err, rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd; logic er; int acks;
    access(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, rd, er);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h12345678; mask = 4'hF;
    @(posedge clk);         // accepted, now in WAIT
    #2 rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    tests++; if (acks !== 0) begin fails++; $display("FAIL rst_no_ack got %0d acks exp 0", acks); end
    access(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er);
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL rst_no_commit got %h exp cafef00d", rd); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_range();
    test_async_reset();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
